// File: rtl/gf180mcu_osu_sc_12t_tbuf_arb_if.sv
// Bus-side signals between the tri-state driver bank (requesters) and the
// enable arbiter.
interface gf180mcu_osu_sc_12t_tbuf_arb_if #(
  parameter int N = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  REQ;
  logic [N-1:0]  EN;
  logic [N-1:0]  EN_BAR;
  logic          BUSY;
  logic [OW-1:0] OWNER;

  // Requester / driver-bank side
  modport master (output REQ, input EN, input EN_BAR, input BUSY, input OWNER);
  // Arbiter side
  modport slave  (input REQ, output EN, output EN_BAR, output BUSY, output OWNER);
endinterface

// File: rtl/gf180mcu_osu_sc_12t_tbuf_arb.sv
// Round-robin arbiter producing registered one-hot EN/EN_BAR pairs for a
// shared tri-state bus, with break-before-make dead cycles and a hold limit.
module gf180mcu_osu_sc_12t_tbuf_arb #(
  parameter int N       = 4,
  parameter int DEAD    = 1,
  parameter int MAXHOLD = 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  gf180mcu_osu_sc_12t_tbuf_arb_if.slave   bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAXHOLD + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DEADT = 2'd2;

  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAXHOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [3:0]    DEAD_INIT = 4'(DEAD - 1);
  localparam logic [N-1:0]  EN_ONE    = N'(1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    dead_q, dead_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [N-1:0]  en_q, en_d;
  logic [N-1:0]  en_bar_q, en_bar_d;
  logic          busy_q, busy_d;

  logic [OW-1:0] win;
  logic          any_req;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // First requesting index at or after ptr, wrapping modulo N.
  function automatic logic [OW-1:0] pick(input logic [N-1:0] req,
                                         input logic [OW-1:0] ptr);
    logic [OW-1:0] cur;
    logic [OW-1:0] w;
    logic          found;
    cur   = ptr;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[cur]) begin
        found = 1'b1;
        w     = cur;
      end
      cur = wrap_inc(cur);
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    en_d    = en_q;
    win     = pick(bus.REQ, ptr_q);
    any_req = |bus.REQ;

    case (state_q)
      IDLE, DEADT: begin
        if (state_q == DEADT && dead_q != 4'd0) begin
          dead_d = dead_q - 4'd1;
        end else if (any_req) begin
          state_d = GRANT;
          en_d    = EN_ONE << win;
          owner_d = win;
          hold_d  = HOLD_ONE;
        end else begin
          state_d = IDLE;
          en_d    = '0;
          owner_d = '0;
        end
      end
      GRANT: begin
        // A dropped request and a timeout on the same edge are one release.
        if (!bus.REQ[owner_q] || hold_q == HOLD_MAX) begin
          state_d = DEADT;
          en_d    = '0;
          owner_d = '0;
          ptr_d   = wrap_inc(owner_q);
          dead_d  = DEAD_INIT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
        owner_d = '0;
        hold_d  = '0;
        dead_d  = '0;
      end
    endcase

    en_bar_d = ~en_d;
    busy_d   = |en_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      dead_q   <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      en_q     <= '0;
      en_bar_q <= '1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      dead_q   <= dead_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      en_q     <= en_d;
      en_bar_q <= en_bar_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.EN     = en_q;
  assign bus.EN_BAR = en_bar_q;
  assign bus.BUSY   = busy_q;
  assign bus.OWNER  = owner_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_tbuf_arb.sv
// Directed bench for the tri-state bus arbiter: two instances (DEAD=1 and
// DEAD=3) driven from one linear stimulus sequence plus a per-cycle monitor.
module tb_gf180mcu_osu_sc_12t_tbuf_arb;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic mon_en;

  gf180mcu_osu_sc_12t_tbuf_arb_if #(.N(4)) ifa ();
  gf180mcu_osu_sc_12t_tbuf_arb_if #(.N(4)) ifb ();

  gf180mcu_osu_sc_12t_tbuf_arb #(.N(4), .DEAD(1), .MAXHOLD(8)) u_a (
    .CLK (clk),
    .RST (rst),
    .bus (ifa.slave)
  );

  gf180mcu_osu_sc_12t_tbuf_arb #(.N(4), .DEAD(3), .MAXHOLD(8)) u_b (
    .CLK (clk),
    .RST (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] ea, input logic [3:0] eb);
    ifa.REQ = ra;
    ifb.REQ = rb;
    tick();
    chk({tag, " EN_a"}, ifa.EN, ea);
    chk({tag, " EN_b"}, ifb.EN, eb);
  endtask

  task automatic inv(input string tag, input logic [3:0] en, input logic [3:0] enb,
                     input logic busy, input int dead, input logic [3:0] prev,
                     input logic [3:0] last_nz, input int zeros);
    logic [3:0] nen;
    nen = ~en;
    chk({tag, " en_bar"}, enb, nen);
    chk({tag, " onehot0"}, $onehot0(en), 1);
    chk({tag, " busy"}, busy, |en);
    if (en != 4'd0 && en != prev)
      chk({tag, " dead gap"}, (prev == 4'd0 && (last_nz == 4'd0 || zeros >= dead)), 1);
  endtask

  logic [3:0] pa, la, pb, lb;
  int         za, zb;

  always @(negedge clk) begin
    if (mon_en) begin
      inv("inv_a", ifa.EN, ifa.EN_BAR, ifa.BUSY, 1, pa, la, za);
      inv("inv_b", ifb.EN, ifb.EN_BAR, ifb.BUSY, 3, pb, lb, zb);
      if (ifa.EN != 4'd0) begin la = ifa.EN; za = 0; end else za++;
      if (ifb.EN != 4'd0) begin lb = ifb.EN; zb = 0; end else zb++;
      pa = ifa.EN;
      pb = ifb.EN;
      if (rst) begin
        la = 4'd0;
        lb = 4'd0;
      end
    end
  end

  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    step(tag, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    pa = 4'd0; la = 4'd0; za = 0;
    pb = 4'd0; lb = 4'd0; zb = 0;

    // Reset with all requests high
    rst     = 1'b1;
    ifa.REQ = 4'hF;
    ifb.REQ = 4'h0;
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst EN", ifa.EN, 4'h0);
    chk("rst EN_BAR", ifa.EN_BAR, 4'hF);
    chk("rst BUSY", ifa.BUSY, 1'b0);
    chk("rst OWNER", ifa.OWNER, 2'd0);
    chk("rst EN_b", ifb.EN, 4'h0);
    rst = 1'b0;
    step("rst_release", 4'hF, 4'h0, 4'h1, 4'h0);
    chk("rst_release OWNER", ifa.OWNER, 2'd0);
    step("rst_drop", 4'h0, 4'h0, 4'h0, 4'h0);
    step("rst_idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Single requester
    step("sgl1", 4'h4, 4'h0, 4'h4, 4'h0);
    chk("sgl1 OWNER", ifa.OWNER, 2'd2);
    step("sgl2", 4'h4, 4'h0, 4'h4, 4'h0);
    step("sgl3", 4'h4, 4'h0, 4'h4, 4'h0);
    chk("sgl3 OWNER", ifa.OWNER, 2'd2);
    step("sgl_rel", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("sgl_rel PTR", u_a.ptr_q, 2'd3);
    chk("sgl_rel OWNER", ifa.OWNER, 2'd0);
    chk("sgl_rel BUSY", ifa.BUSY, 1'b0);
    step("sgl_idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Round robin over 1011: order 0,1,3,0
    rst_pulse("rr_rst");
    step("rr0a", 4'hB, 4'h0, 4'h1, 4'h0);
    step("rr0b", 4'hB, 4'h0, 4'h1, 4'h0);
    step("rr0c", 4'hA, 4'h0, 4'h0, 4'h0);
    step("rr1a", 4'hB, 4'h0, 4'h2, 4'h0);
    chk("rr1a OWNER", ifa.OWNER, 2'd1);
    step("rr1b", 4'hB, 4'h0, 4'h2, 4'h0);
    step("rr1c", 4'h9, 4'h0, 4'h0, 4'h0);
    step("rr3a", 4'hB, 4'h0, 4'h8, 4'h0);
    chk("rr3a OWNER", ifa.OWNER, 2'd3);
    step("rr3b", 4'hB, 4'h0, 4'h8, 4'h0);
    step("rr3c", 4'h3, 4'h0, 4'h0, 4'h0);
    step("rr0d", 4'hB, 4'h0, 4'h1, 4'h0);
    step("rr_end", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("rr_end PTR", u_a.ptr_q, 2'd1);
    step("rr_idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Hold timeout with 0011 held
    rst_pulse("to_rst");
    for (int i = 0; i < 8; i++) step("to_own0", 4'h3, 4'h0, 4'h1, 4'h0);
    step("to_dead0", 4'h3, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) step("to_own1", 4'h3, 4'h0, 4'h2, 4'h0);
    step("to_dead1", 4'h3, 4'h0, 4'h0, 4'h0);
    step("to_back0", 4'h3, 4'h0, 4'h1, 4'h0);
    step("to_drop", 4'h0, 4'h0, 4'h0, 4'h0);
    step("to_idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // DEAD=3 instance with 0110 held
    rst_pulse("dt_rst");
    for (int i = 0; i < 8; i++) step("dt_own1", 4'h0, 4'h6, 4'h0, 4'h2);
    for (int i = 0; i < 3; i++) step("dt_gap1", 4'h0, 4'h6, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) step("dt_own2", 4'h0, 4'h6, 4'h0, 4'h4);
    for (int i = 0; i < 3; i++) step("dt_gap2", 4'h0, 4'h6, 4'h0, 4'h0);
    step("dt_back1", 4'h0, 4'h6, 4'h0, 4'h2);
    chk("dt_back1 OWNER", ifb.OWNER, 2'd1);

    // Mid-grant reset, then simultaneous drop and timeout
    rst_pulse("mg_rst0");
    for (int i = 0; i < 5; i++) step("mg_own3", 4'h8, 4'h0, 4'h8, 4'h0);
    chk("mg hold", u_a.hold_q, 4'd5);
    rst = 1'b1;
    step("mg_rst", 4'h9, 4'h0, 4'h0, 4'h0);
    chk("mg_rst PTR", u_a.ptr_q, 2'd0);
    chk("mg_rst EN_BAR", ifa.EN_BAR, 4'hF);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step("mg_own0", 4'h9, 4'h0, 4'h1, 4'h0);
    step("both_rel", 4'h8, 4'h0, 4'h0, 4'h0);
    chk("both_rel PTR", u_a.ptr_q, 2'd1);
    step("both_next", 4'h8, 4'h0, 4'h8, 4'h0);
    step("fin_drop", 4'h0, 4'h0, 4'h0, 4'h0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
